// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register with zero fill behind the outgoing word.
// Define PISO_STATUS_EN to add the busy output and its bit counter.
module piso_shift_register #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
`ifdef PISO_STATUS_EN
  output logic             busy,
`endif
  output logic             serial_out
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = parallel_in;
    end else if (MSB_FIRST) begin
      sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  // Taken straight from the register so the first bit appears on the load edge.
  assign serial_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

`ifdef PISO_STATUS_EN
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntFull;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);
`endif

endmodule

// File: tb/tb_piso_shift_register.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share the same stimulus.
module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] parallel_in;
  logic       so_msb;
  logic       so_lsb;
`ifdef PISO_STATUS_EN
  logic       busy_msb;
  logic       busy_lsb;
`endif

  int checks = 0;
  int errors = 0;

  logic q_msb[$];
  logic q_lsb[$];
  logic q_busy[$];

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .parallel_in(parallel_in),
`ifdef PISO_STATUS_EN
    .busy       (busy_msb),
`endif
    .serial_out (so_msb)
  );

  piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .parallel_in(parallel_in),
`ifdef PISO_STATUS_EN
    .busy       (busy_lsb),
`endif
    .serial_out (so_lsb)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_sb();
    q_msb.delete();
    q_lsb.delete();
    q_busy.delete();
  endtask

  task automatic check_outputs(input string tag);
    logic em, el, eb;
    em = 1'b0;
    el = 1'b0;
    eb = 1'b0;
    if (q_msb.size() != 0) em = q_msb.pop_front();
    if (q_lsb.size() != 0) el = q_lsb.pop_front();
    if (q_busy.size() != 0) eb = q_busy.pop_front();
    check_val({tag, "_msb"}, 32'(so_msb), 32'(em));
    check_val({tag, "_lsb"}, 32'(so_lsb), 32'(el));
`ifdef PISO_STATUS_EN
    check_val({tag, "_busy_msb"}, 32'(busy_msb), 32'(eb));
    check_val({tag, "_busy_lsb"}, 32'(busy_lsb), 32'(eb));
`endif
  endtask

  // Called at a falling edge; drives, crosses one rising edge, samples at the next fall.
  task automatic step(input string tag, input logic ld, input logic [3:0] d);
    load        = ld;
    parallel_in = d;
    if (ld) begin
      clear_sb();
      for (int k = 0; k < 4; k++) begin
        q_msb.push_back(d[3-k]);
        q_lsb.push_back(d[k]);
        q_busy.push_back(1'b1);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    reset       = 1'b1;
    load        = 1'b0;
    parallel_in = 4'h0;
    #2;
    check_outputs("reset_async");
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset_held");
    reset = 1'b0;

    for (int i = 0; i < 3; i++) step("idle", 1'b0, 4'h0);

    step("w1011", 1'b1, 4'b1011);
    for (int i = 0; i < 6; i++) step("w1011_sh", 1'b0, 4'h0);

    step("w0101", 1'b1, 4'b0101);
    for (int i = 0; i < 5; i++) step("w0101_sh", 1'b0, 4'h0);

    step("w1111", 1'b1, 4'b1111);
    step("w1111_sh", 1'b0, 4'h0);
    step("w1111_sh", 1'b0, 4'h0);
    step("w0001", 1'b1, 4'b0001);
    for (int i = 0; i < 5; i++) step("w0001_sh", 1'b0, 4'h0);

    for (int i = 0; i < 3; i++) step("hold_ld", 1'b1, 4'b1011);
    for (int i = 0; i < 5; i++) step("hold_sh", 1'b0, 4'h0);

    step("rst_ld", 1'b1, 4'b1011);
    step("rst_sh", 1'b0, 4'h0);
    #2;
    reset = 1'b1;
    clear_sb();
    #1;
    check_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    check_outputs("rst_mid_held");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step("rst_after", 1'b0, 4'h0);

    step("w1000", 1'b1, 4'b1000);
    for (int i = 0; i < 5; i++) step("w1000_sh", 1'b0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
